// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// subtractor_pkg
//   Shared definitions for the serial subtractor family.
//   - state_e   : FSM state encoding (IDLE / RUN / DONE)
//   - cnt_width : width of a step counter that must hold 0 .. n-1
// -----------------------------------------------------------------------------
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // One bit more than strictly needed so n = 1 still gets a 1-bit counter.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Request/result bundle of the serial subtractor.
//   master : drives start/a/b/bin, observes busy/done/D/B
//   slave  : the subtractor itself
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             B;

    modport master (output start, a, b, bin, input  busy, done, D, B);
    modport slave  (input  start, a, b, bin, output busy, done, D, B);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit x - y - br.
//   Ports: x (minuend bit), y (subtrahend bit), br (borrow in),
//          d (difference bit), bo (borrow out)
//   Built as two cascaded half-subtractors whose borrows are OR-ed.
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic bo
);
    logic d1, b1, b2;

    // first half-subtractor: x - y
    assign d1 = x ^ y;
    assign b1 = ~x & y;
    // second half-subtractor: (x - y) - br
    assign d  = d1 ^ br;
    assign b2 = ~d1 & br;

    assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle D = a - b - bin over WIDTH bits, DIGIT bits per clock.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : serial_subtractor_if.slave
//             start/a/b/bin in; busy/done/D/B out (all outputs registered)
//   Latency from accepted start to done is WIDTH/DIGIT cycles.
// -----------------------------------------------------------------------------
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bo_q, bo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Slice chain: borrow ripples LSB -> MSB within one step.
    logic [DIGIT:0]   brc;
    logic [DIGIT-1:0] dig;

    assign brc[0] = br_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        full_subtractor u_fs (
            .x  (a_q[i]),
            .y  (b_q[i]),
            .br (brc[i]),
            .d  (dig[i]),
            .bo (brc[i+1])
        );
    end

    // The minuend register doubles as the result register: difference bits
    // enter at the MSB end while consumed minuend bits leave at the LSB end,
    // so after N steps it holds the full difference.
    logic [WIDTH-1:0] a_sh, b_sh;

    if (DIGIT == WIDTH) begin : g_one_step
        assign a_sh = dig;
        assign b_sh = '0;
    end else begin : g_multi_step
        assign a_sh = {dig, a_q[WIDTH-1:DIGIT]};
        assign b_sh = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        bo_d    = bo_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_sh;
                b_d   = b_sh;
                br_d  = brc[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    res_d   = a_sh;
                    bo_d    = brc[DIGIT];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // busy/done are registered images of the next state
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.D    = res_q;
    assign bus.B    = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Two instances: WIDTH=8/DIGIT=1 (sel=0) and WIDTH=16/DIGIT=4 (sel=1).
//   Expected results come from plain integer arithmetic on the operands.
//   Inputs change at negedge or #1 after posedge; outputs sampled #1 after
//   posedge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk (clk), .rst_n (rst_n), .bus (if8.slave)
    );
    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk (clk), .rst_n (rst_n), .bus (if16.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, difference mod 2^w}
    function automatic logic [16:0] ref_sub(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic bin);
        longint diff, m;
        logic [15:0] dd;
        logic br;
        diff = longint'(a) - longint'(b) - longint'(bin);
        m    = longint'(1) << w;
        dd   = 16'(((diff % m) + m) % m);
        br   = longint'(a) < (longint'(b) + longint'(bin));
        return {br, dd};
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? if16.busy : if8.busy;
    endfunction
    function automatic logic cur_done(input bit sel);
        return sel ? if16.done : if8.done;
    endfunction
    function automatic logic [15:0] cur_d(input bit sel);
        return sel ? if16.D : {8'h00, if8.D};
    endfunction
    function automatic logic cur_b(input bit sel);
        return sel ? if16.B : if8.B;
    endfunction

    task automatic drive(input bit sel, input bit st, input logic [15:0] a,
                         input logic [15:0] b, input bit bin);
        if (sel) begin
            if16.start = st; if16.a = a; if16.b = b; if16.bin = bin;
        end else begin
            if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bin;
        end
    endtask

    // Called #1 after the accepting edge. Counts cycles to done, busy samples
    // (including the current one) and changes of D before done.
    // mode 1 raises start with other operands mid-run (must be ignored).
    task automatic wait_done(input bit sel, input int mode, output int cyc,
                             output int bcnt, output int dchg);
        logic [15:0] d0;
        d0   = cur_d(sel);
        cyc  = 0;
        dchg = 0;
        bcnt = cur_busy(sel) ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (cur_done(sel)) break;
            if (cur_busy(sel)) bcnt++;
            if (cur_d(sel) !== d0) dchg++;
            if (mode == 1 && cyc == 3) drive(sel, 1'b1, 16'h00AA, 16'h0055, 1'b1);
            if (mode == 1 && cyc == 4) drive(sel, 1'b0, 16'h0000, 16'h0000, 1'b0);
        end
    endtask

    // mode 2 keeps start high afterwards with a=0x10, b=0x01 for back-to-back.
    task automatic op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                      input bit bin, input int mode, output logic [15:0] d,
                      output bit bo, output int cyc, output int bcnt);
        int dchg;
        @(negedge clk);
        drive(sel, 1'b1, a, b, bin);
        @(posedge clk); #1;
        if (mode == 2) drive(sel, 1'b1, 16'h0010, 16'h0001, 1'b0);
        else           drive(sel, 1'b0, a, b, bin);
        wait_done(sel, mode, cyc, bcnt, dchg);
        chk("d_held_during_run", dchg, 0);
        d  = cur_d(sel);
        bo = cur_b(sel);
    endtask

    initial begin
        logic [15:0] d, ra, rb;
        logic [16:0] e;
        bit bo, rbin;
        int cyc, bcnt, dchg, nd;

        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        #22;
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        chk("rst_D", if8.D, 0);
        chk("rst_B", if8.B, 0);
        @(negedge clk); rst_n = 1'b1;

        // basic 0x35 - 0x12
        op(0, 16'h35, 16'h12, 0, 0, d, bo, cyc, bcnt);
        chk("t1_latency", cyc, 8);
        chk("t1_busy_cycles", bcnt, 8);
        chk("t1_D", d, 16'h23);
        chk("t1_B", bo, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse_falls", if8.done, 0);
        chk("t1_D_holds", if8.D, 8'h23);

        op(0, 16'h00, 16'h01, 0, 0, d, bo, cyc, bcnt);
        chk("t2_D", d, 16'hFF);
        chk("t2_B", bo, 1);

        op(0, 16'h80, 16'h80, 1, 0, d, bo, cyc, bcnt);
        chk("t3_D", d, 16'hFF);
        chk("t3_B", bo, 1);

        op(0, 16'hFF, 16'h00, 0, 0, d, bo, cyc, bcnt);
        chk("t4_D", d, 16'hFF);
        chk("t4_B", bo, 0);

        // start mid-run with other operands is ignored
        op(0, 16'h5A, 16'h21, 0, 1, d, bo, cyc, bcnt);
        e = ref_sub(8, 16'h5A, 16'h21, 0);
        chk("t5_D", d, e[15:0]);
        chk("t5_B", bo, e[16]);
        chk("t5_latency", cyc, 8);
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.done) nd++;
        end
        chk("t5_single_done", nd, 0);

        // back-to-back: start held through DONE; accepted at the edge leaving
        // DONE, so its result arrives N cycles after that edge
        op(0, 16'h44, 16'h22, 0, 2, d, bo, cyc, bcnt);
        chk("t6_first_D", d, 16'h22);
        @(posedge clk); #1;
        chk("t6_rerun_busy", if8.busy, 1);
        chk("t6_rerun_done_low", if8.done, 0);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        wait_done(0, 0, cyc, bcnt, dchg);
        chk("t6_second_latency", cyc, 8);
        chk("t6_second_D", if8.D, 8'h0F);
        chk("t6_second_B", if8.B, 0);
        chk("t6_second_hold", dchg, 0);

        // reset at RUN cycle 4 aborts the operation
        @(negedge clk);
        drive(0, 1'b1, 16'hC3, 16'h01, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", if8.busy, 0);
        chk("rst_mid_done", if8.done, 0);
        chk("rst_mid_D", if8.D, 0);
        chk("rst_mid_B", if8.B, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.done || if8.busy) nd++;
        end
        chk("rst_mid_no_done", nd, 0);

        // 16-bit, 4 bits per step
        op(1, 16'h1234, 16'h0235, 0, 0, d, bo, cyc, bcnt);
        chk("w16_latency", cyc, 4);
        chk("w16_busy_cycles", bcnt, 4);
        chk("w16_D", d, 16'h0FFF);
        chk("w16_B", bo, 0);

        op(1, 16'h0000, 16'hFFFF, 1, 0, d, bo, cyc, bcnt);
        chk("w16_wrap_D", d, 16'h0000);
        chk("w16_wrap_B", bo, 1);

        op(1, 16'hFFFF, 16'hFFFF, 1, 0, d, bo, cyc, bcnt);
        chk("w16_eq_D", d, 16'hFFFF);
        chk("w16_eq_B", bo, 1);

        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom_range(0, 65535));
            rb   = 16'($urandom_range(0, 65535));
            rbin = 1'($urandom_range(0, 1));
            op(1, ra, rb, rbin, 0, d, bo, cyc, bcnt);
            e = ref_sub(16, ra, rb, rbin);
            chk("rnd16_D", d, e[15:0]);
            chk("rnd16_B", bo, e[16]);
            chk("rnd16_latency", cyc, 4);
        end

        for (int i = 0; i < 25; i++) begin
            ra   = 16'($urandom_range(0, 255));
            rb   = 16'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            op(0, ra, rb, rbin, 0, d, bo, cyc, bcnt);
            e = ref_sub(8, ra, rb, rbin);
            chk("rnd8_D", d, e[15:0]);
            chk("rnd8_B", bo, e[16]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
